// File: rtl/mem_stage_bus_pkg.sv
// Shared definitions for the MEM stage: memory op encodings, exception codes,
// FSM states and CP0 Status/Cause bit positions.
package mem_stage_bus_pkg;

  typedef enum logic [3:0] {
    MEM_NOP = 4'd0,
    MEM_LB  = 4'd1,
    MEM_LBU = 4'd2,
    MEM_LH  = 4'd3,
    MEM_LHU = 4'd4,
    MEM_LW  = 4'd5,
    MEM_SB  = 4'd6,
    MEM_SH  = 4'd7,
    MEM_SW  = 4'd8
  } ram_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_DBE  = 5'h07;

  localparam int SR_IE  = 0;
  localparam int SR_EXL = 1;
  localparam int SR_IM  = 8;
  localparam int CR_IP  = 8;

  function automatic logic op_is_load(input ram_op_e op);
    return op inside {MEM_LB, MEM_LBU, MEM_LH, MEM_LHU, MEM_LW};
  endfunction

  function automatic logic op_is_store(input ram_op_e op);
    return op inside {MEM_SB, MEM_SH, MEM_SW};
  endfunction

  function automatic logic op_misaligned(input ram_op_e op, input logic [1:0] off);
    logic bad;
    bad = 1'b0;
    case (op)
      MEM_LH, MEM_LHU, MEM_SH: bad = off[0];
      MEM_LW, MEM_SW:          bad = |off;
      default:                 bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_stage_bus_if.sv
// Request/acknowledge data bus between the MEM stage (master) and memory (slave).
interface mem_stage_bus_if #(
  parameter int ADDR_W = 32
) ();
  logic              req;
  logic              we;
  logic [3:0]        be;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic              ack;
  logic              err;
  logic [31:0]       rdata;

  modport master (output req, we, be, addr, wdata, input ack, err, rdata);
  modport slave  (input req, we, be, addr, wdata, output ack, err, rdata);
endinterface

// File: rtl/mem_stage_bus_align.sv
// Combinational lane logic: byte enables and replicated store data on the way
// out, lane select and sign/zero extension of load data on the way back.
module mem_align
  import mem_stage_bus_pkg::*;
(
  input  ram_op_e     st_op,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_data,
  output logic [3:0]  be,
  output logic [31:0] bus_wdata,
  input  ram_op_e     ld_op,
  input  logic [1:0]  ld_off,
  input  logic [31:0] rdata,
  output logic [31:0] ld_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    be        = 4'b0000;
    bus_wdata = st_data;
    case (st_op)
      MEM_LB, MEM_LBU, MEM_SB: begin
        be        = 4'b0001 << st_off;
        bus_wdata = {4{st_data[7:0]}};
      end
      MEM_LH, MEM_LHU, MEM_SH: begin
        be        = st_off[1] ? 4'b1100 : 4'b0011;
        bus_wdata = {2{st_data[15:0]}};
      end
      MEM_LW, MEM_SW: be = 4'b1111;
      default:        be = 4'b0000;
    endcase
  end

  always_comb begin
    byte_sel = rdata[{ld_off, 3'b000} +: 8];
    half_sel = ld_off[1] ? rdata[31:16] : rdata[15:0];
    case (ld_op)
      MEM_LB:  ld_data = {{24{byte_sel[7]}}, byte_sel};
      MEM_LBU: ld_data = {24'h0, byte_sel};
      MEM_LH:  ld_data = {{16{half_sel[15]}}, half_sel};
      MEM_LHU: ld_data = {16'h0, half_sel};
      default: ld_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage_bus.sv
// MEM pipeline stage: exception priority, bus transfer FSM with timeout, and
// the registered MEM/WB outputs.
//
//   state    | meaning
//   ST_IDLE  | no transfer outstanding; non-mem/excepting instrs retire here
//   ST_BUSY  | request held, waiting for ack, error or timeout
//   ST_DRAIN | flushed mid-transfer; request held until bus completes, result dropped
module mem_stage_bus
  import mem_stage_bus_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int NUM_IRQ = 8,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid,
  input  logic [3:0]        ram_op,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  input  logic [31:0]       alu_res,
  input  logic              wr_en,
  input  logic [4:0]        wr_addr,
  input  logic              up_exc_valid,
  input  logic [4:0]        up_exc_code,
  input  logic [31:0]       status,
  input  logic [31:0]       cause,
  input  logic              flush,
  mem_stage_bus_if.master   bus,
  output logic              stall,
  output logic              wb_valid,
  output logic              wb_wr_en,
  output logic [4:0]        wb_wr_addr,
  output logic [31:0]       wb_data,
  output logic              exc_valid,
  output logic [4:0]        exc_code,
  output logic [ADDR_W-1:0] bad_vaddr
);

  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  state_e            state, state_next;
  ram_op_e           op, op_q;
  logic [ADDR_W-1:0] addr_q;
  logic              wr_en_q;
  logic [4:0]        wr_addr_q;
  logic [CNT_W-1:0]  cnt;
  logic              timeout;

  logic              irq_pend, adr_err, is_mem, exc_det, ade_sel;
  logic [4:0]        exc_det_code;
  logic              start, retire, done_ok, done_err, drop;

  logic [3:0]        al_be;
  logic [31:0]       al_wdata, al_ld_data;
  logic              unused_bits;

  assign op          = ram_op_e'(ram_op);
  assign unused_bits = ^{status, cause};

  assign irq_pend = (|(status[SR_IM +: NUM_IRQ] & cause[CR_IP +: NUM_IRQ]))
                    & status[SR_IE] & ~status[SR_EXL];
  assign is_mem   = op_is_load(op) | op_is_store(op);
  assign adr_err  = is_mem & op_misaligned(op, addr[1:0]);
  assign exc_det  = valid & (irq_pend | adr_err | up_exc_valid);
  assign ade_sel  = adr_err & ~irq_pend;
  assign timeout  = (cnt == CNT_W'(TIMEOUT));

  always_comb begin
    exc_det_code = up_exc_code;
    if (adr_err)  exc_det_code = op_is_store(op) ? EXC_ADES : EXC_ADEL;
    if (irq_pend) exc_det_code = EXC_INT;
  end

  mem_align u_align (
    .st_op     (op),
    .st_off    (addr[1:0]),
    .st_data   (wdata),
    .be        (al_be),
    .bus_wdata (al_wdata),
    .ld_op     (op_q),
    .ld_off    (addr_q[1:0]),
    .rdata     (bus.rdata),
    .ld_data   (al_ld_data)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Stall also drops on timeout so the faulting instruction leaves EX/MEM
  // instead of being re-issued when we return to IDLE.
  always_comb begin
    state_next = state;
    stall      = 1'b0;
    start      = 1'b0;
    retire     = 1'b0;
    done_ok    = 1'b0;
    done_err   = 1'b0;
    drop       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (valid && !flush) begin
          if (is_mem && !exc_det) begin
            stall      = 1'b1;
            start      = 1'b1;
            state_next = ST_BUSY;
          end else begin
            retire = 1'b1;
          end
        end
      end
      ST_BUSY: begin
        stall = ~(bus.ack | timeout);
        if (flush) begin
          stall = 1'b1;
          if (bus.ack || timeout) begin
            drop       = 1'b1;
            state_next = ST_IDLE;
          end else begin
            state_next = ST_DRAIN;
          end
        end else if (bus.ack && !bus.err) begin
          done_ok    = 1'b1;
          state_next = ST_IDLE;
        end else if (bus.ack || timeout) begin
          done_err   = 1'b1;
          state_next = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        stall = 1'b1;
        if (bus.ack || timeout) begin
          drop       = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.req    <= 1'b0;
      bus.we     <= 1'b0;
      bus.be     <= 4'b0000;
      bus.addr   <= '0;
      bus.wdata  <= '0;
      op_q       <= MEM_NOP;
      addr_q     <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      cnt        <= '0;
      wb_valid   <= 1'b0;
      wb_wr_en   <= 1'b0;
      wb_wr_addr <= '0;
      wb_data    <= '0;
      exc_valid  <= 1'b0;
      exc_code   <= '0;
      bad_vaddr  <= '0;
    end else begin
      wb_valid  <= 1'b0;
      wb_wr_en  <= 1'b0;
      exc_valid <= 1'b0;

      if (start) begin
        bus.req   <= 1'b1;
        bus.we    <= op_is_store(op);
        bus.be    <= al_be;
        bus.addr  <= {addr[ADDR_W-1:2], 2'b00};
        bus.wdata <= al_wdata;
        op_q      <= op;
        addr_q    <= addr;
        wr_en_q   <= wr_en;
        wr_addr_q <= wr_addr;
        cnt       <= '0;
      end else if (state != ST_IDLE) begin
        if (done_ok || done_err || drop) bus.req <= 1'b0;
        else if (!timeout)               cnt     <= cnt + CNT_W'(1);
      end

      if (retire) begin
        wb_valid   <= 1'b1;
        wb_wr_en   <= wr_en & ~exc_det;
        wb_wr_addr <= wr_addr;
        wb_data    <= alu_res;
        exc_valid  <= exc_det;
        exc_code   <= exc_det ? exc_det_code : 5'h00;
        if (ade_sel) bad_vaddr <= addr;
      end

      if (done_ok) begin
        wb_valid   <= 1'b1;
        wb_wr_en   <= wr_en_q & op_is_load(op_q);
        wb_wr_addr <= wr_addr_q;
        wb_data    <= al_ld_data;
      end

      if (done_err) begin
        wb_valid   <= 1'b1;
        wb_wr_addr <= wr_addr_q;
        exc_valid  <= 1'b1;
        exc_code   <= EXC_DBE;
        bad_vaddr  <= addr_q;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_bus.sv
// Directed bench for mem_stage_bus: scoreboard of expected WB/exception
// results, immediate-assertion checks at every comparison point.
module tb_mem_stage_bus;
  import mem_stage_bus_pkg::*;

  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [3:0]  ram_op;
  logic [31:0] addr, wdata, alu_res, status, cause;
  logic        wr_en, up_exc_valid, flush;
  logic [4:0]  wr_addr, up_exc_code;
  logic        stall, wb_valid, wb_wr_en, exc_valid;
  logic [4:0]  wb_wr_addr, exc_code;
  logic [31:0] wb_data, bad_vaddr;

  mem_stage_bus_if #(.ADDR_W(32)) bus ();

  mem_stage_bus #(.ADDR_W(32), .NUM_IRQ(8), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .valid(valid), .ram_op(ram_op), .addr(addr),
    .wdata(wdata), .alu_res(alu_res), .wr_en(wr_en), .wr_addr(wr_addr),
    .up_exc_valid(up_exc_valid), .up_exc_code(up_exc_code),
    .status(status), .cause(cause), .flush(flush), .bus(bus),
    .stall(stall), .wb_valid(wb_valid), .wb_wr_en(wb_wr_en),
    .wb_wr_addr(wb_wr_addr), .wb_data(wb_data), .exc_valid(exc_valid),
    .exc_code(exc_code), .bad_vaddr(bad_vaddr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] data;
    bit          chk_data;
    logic        exc;
    logic [4:0]  code;
    logic [31:0] bva;
    bit          chk_bva;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_load(input ram_op_e op, input logic [1:0] off, input logic [31:0] r);
    logic [31:0] sh;
    logic [31:0] res;
    sh = r >> (8 * off);
    case (op)
      MEM_LB:  res = {{24{sh[7]}}, sh[7:0]};
      MEM_LBU: res = {24'h0, sh[7:0]};
      MEM_LH:  res = (off == 2'd2) ? {{16{r[31]}}, r[31:16]} : {{16{r[15]}}, r[15:0]};
      MEM_LHU: res = (off == 2'd2) ? {16'h0, r[31:16]} : {16'h0, r[15:0]};
      default: res = r;
    endcase
    return res;
  endfunction

  function automatic logic [3:0] m_be(input ram_op_e op, input logic [1:0] off);
    logic [3:0] b;
    case (op)
      MEM_SB:  b = (off == 2'd0) ? 4'b0001 : (off == 2'd1) ? 4'b0010 : (off == 2'd2) ? 4'b0100 : 4'b1000;
      MEM_SH:  b = (off == 2'd2) ? 4'b1100 : 4'b0011;
      default: b = 4'b1111;
    endcase
    return b;
  endfunction

  function automatic logic [31:0] m_wdata(input ram_op_e op, input logic [31:0] d);
    logic [31:0] w;
    case (op)
      MEM_SB:  w = {d[7:0], d[7:0], d[7:0], d[7:0]};
      MEM_SH:  w = {d[15:0], d[15:0]};
      default: w = d;
    endcase
    return w;
  endfunction

  task automatic mon();
    exp_t e;
    if (wb_valid === 1'b1 || exc_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_wb", {30'h0, wb_valid, exc_valid}, 32'h0);
      end else begin
        e = sb.pop_front();
        chk("wb_valid", wb_valid, 1'b1);
        chk("wb_wr_en", wb_wr_en, e.wr_en);
        chk("wb_wr_addr", wb_wr_addr, e.wr_addr);
        if (e.chk_data) chk("wb_data", wb_data, e.data);
        chk("exc_valid", exc_valid, e.exc);
        if (e.exc) chk("exc_code", exc_code, e.code);
        if (e.chk_bva) chk("bad_vaddr", bad_vaddr, e.bva);
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    mon();
  endtask

  task automatic clear_inputs();
    valid = 1'b0; ram_op = MEM_NOP; addr = '0; wdata = '0; alu_res = '0;
    wr_en = 1'b0; wr_addr = '0; up_exc_valid = 1'b0; up_exc_code = '0;
    flush = 1'b0; bus.ack = 1'b0; bus.err = 1'b0; bus.rdata = '0;
  endtask

  // delay = BUSY cycles without ack before the ack cycle
  task automatic mem_xfer(input ram_op_e op, input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] rd, input int delay, input logic err,
                          input logic wre, input logic [4:0] wra);
    logic st;
    int   stalls;
    exp_t e;
    st = (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
    valid = 1'b1; ram_op = op; addr = a; wdata = wd; wr_en = wre; wr_addr = wra;
    #1;
    chk("stall_accept", stall, 1'b1);
    chk("req_before_rise", bus.req, 1'b0);
    stalls = 1;
    tick();
    chk("req_rise", bus.req, 1'b1);
    chk("bus_addr", bus.addr, {a[31:2], 2'b00});
    chk("bus_we", bus.we, st);
    if (st) begin
      chk("bus_be", bus.be, m_be(op, a[1:0]));
      chk("bus_wdata", bus.wdata, m_wdata(op, wd));
    end
    for (int k = 0; k < delay; k++) begin
      stalls += int'(stall);
      tick();
    end
    bus.ack = 1'b1; bus.err = err; bus.rdata = rd;
    #1;
    chk("req_at_ack", bus.req, 1'b1);
    chk("bus_addr_stable", bus.addr, {a[31:2], 2'b00});
    if (st) chk("bus_be_stable", bus.be, m_be(op, a[1:0]));
    chk("stall_ack", stall, 1'b0);
    chk("stall_cycles", stalls, delay + 1);
    e.wr_addr = wra; e.code = EXC_DBE; e.bva = a;
    if (err) begin
      e.wr_en = 1'b0; e.data = '0; e.chk_data = 1'b0; e.exc = 1'b1; e.chk_bva = 1'b1;
    end else begin
      e.wr_en = wre & ~st; e.data = m_load(op, a[1:0], rd); e.chk_data = !st;
      e.exc = 1'b0; e.chk_bva = 1'b0;
    end
    sb.push_back(e);
    tick();
    bus.ack = 1'b0; bus.err = 1'b0; valid = 1'b0; ram_op = MEM_NOP;
    chk("req_drop", bus.req, 1'b0);
    chk("sb_empty", sb.size(), 0);
  endtask

  task automatic retire(input ram_op_e op, input logic [31:0] a, input logic [31:0] alu,
                        input logic wre, input logic [4:0] wra, input logic upv,
                        input logic [4:0] upc, input logic exp_exc, input logic [4:0] exp_code,
                        input logic chk_bva);
    exp_t e;
    valid = 1'b1; ram_op = op; addr = a; alu_res = alu; wr_en = wre; wr_addr = wra;
    up_exc_valid = upv; up_exc_code = upc;
    #1;
    chk("stall_retire", stall, 1'b0);
    e.wr_en = wre & ~exp_exc; e.wr_addr = wra; e.data = alu; e.chk_data = !exp_exc;
    e.exc = exp_exc; e.code = exp_code; e.bva = a; e.chk_bva = chk_bva;
    sb.push_back(e);
    tick();
    chk("no_req", bus.req, 1'b0);
    valid = 1'b0; ram_op = MEM_NOP; up_exc_valid = 1'b0;
    chk("sb_empty", sb.size(), 0);
  endtask

  initial begin
    int   n;
    exp_t e;
    clear_inputs();
    status = 32'h0; cause = 32'h0;
    rst = 1'b1;
    tick();
    tick();
    chk("rst_req", bus.req, 1'b0);
    chk("rst_we", bus.we, 1'b0);
    chk("rst_be", bus.be, 4'b0000);
    chk("rst_stall", stall, 1'b0);
    chk("rst_wb_valid", wb_valid, 1'b0);
    chk("rst_wb_wr_en", wb_wr_en, 1'b0);
    chk("rst_wb_data", wb_data, 32'h0);
    chk("rst_exc_valid", exc_valid, 1'b0);
    chk("rst_exc_code", exc_code, 5'h0);
    chk("rst_bad_vaddr", bad_vaddr, 32'h0);
    rst = 1'b0;
    tick();

    // pass-through ALU result
    retire(MEM_NOP, 32'h0, 32'h1234_5678, 1'b1, 5'd3, 1'b0, 5'h0, 1'b0, 5'h0, 1'b0);

    // loads
    mem_xfer(MEM_LW,  32'h1000, 32'h0, 32'hDEAD_BEEF, 2, 1'b0, 1'b1, 5'd5);
    chk("lw_const", wb_data, 32'hDEAD_BEEF);
    mem_xfer(MEM_LB,  32'h1003, 32'h0, 32'h80FF_FFFF, 0, 1'b0, 1'b1, 5'd6);
    chk("lb_const", wb_data, 32'hFFFF_FF80);
    mem_xfer(MEM_LBU, 32'h1003, 32'h0, 32'h80FF_FFFF, 1, 1'b0, 1'b1, 5'd7);
    chk("lbu_const", wb_data, 32'h0000_0080);
    mem_xfer(MEM_LH,  32'h1002, 32'h0, 32'h8001_1234, 0, 1'b0, 1'b1, 5'd8);
    mem_xfer(MEM_LHU, 32'h1000, 32'h0, 32'h8001_9234, 1, 1'b0, 1'b1, 5'd9);

    // stores
    mem_xfer(MEM_SH, 32'h2002, 32'h0000_ABCD, 32'h0, 1, 1'b0, 1'b0, 5'd0);
    mem_xfer(MEM_SB, 32'h2001, 32'h0000_005A, 32'h0, 0, 1'b0, 1'b0, 5'd0);
    mem_xfer(MEM_SW, 32'h2004, 32'h0BAD_F00D, 32'h0, 3, 1'b0, 1'b0, 5'd0);

    // address errors and upstream exceptions
    retire(MEM_LW, 32'h1002, 32'h1002, 1'b1, 5'd4, 1'b0, 5'h0, 1'b1, EXC_ADEL, 1'b1);
    retire(MEM_SH, 32'h0011, 32'h0011, 1'b0, 5'd0, 1'b0, 5'h0, 1'b1, EXC_ADES, 1'b1);
    retire(MEM_NOP, 32'h40, 32'h77, 1'b1, 5'd7, 1'b1, 5'h0C, 1'b1, 5'h0C, 1'b0);
    retire(MEM_LW, 32'h1001, 32'h1001, 1'b1, 5'd7, 1'b1, 5'h0A, 1'b1, EXC_ADEL, 1'b1);

    // interrupt pending beats a store; masked by EXL it proceeds
    status = 32'h0000_0401; cause = 32'h0000_0400;
    retire(MEM_SW, 32'h2000, 32'h2000, 1'b0, 5'd0, 1'b0, 5'h0, 1'b1, EXC_INT, 1'b0);
    status = 32'h0000_0403;
    mem_xfer(MEM_SW, 32'h2010, 32'hCAFE_F00D, 32'h0, 1, 1'b0, 1'b0, 5'd0);
    status = 32'h0; cause = 32'h0;

    // bus error with ack
    mem_xfer(MEM_LW, 32'h3000, 32'h0, 32'h1111_1111, 1, 1'b1, 1'b1, 5'd10);

    // timeout
    valid = 1'b1; ram_op = MEM_LW; addr = 32'h3004; wr_en = 1'b1; wr_addr = 5'd11;
    tick();
    e.wr_en = 1'b0; e.wr_addr = 5'd11; e.data = '0; e.chk_data = 1'b0;
    e.exc = 1'b1; e.code = EXC_DBE; e.bva = 32'h3004; e.chk_bva = 1'b1;
    sb.push_back(e);
    n = 0;
    while (bus.req === 1'b1 && n < 4 * TO) begin
      n++;
      tick();
    end
    valid = 1'b0; ram_op = MEM_NOP;
    chk("timeout_req_cycles", n, TO + 1);
    chk("timeout_req_drop", bus.req, 1'b0);
    chk("sb_empty", sb.size(), 0);

    // flush during BUSY drains the transfer silently
    valid = 1'b1; ram_op = MEM_LW; addr = 32'h3008; wr_en = 1'b1; wr_addr = 5'd12;
    tick();
    chk("flush_req_busy", bus.req, 1'b1);
    flush = 1'b1;
    #1;
    chk("flush_stall", stall, 1'b1);
    tick();
    flush = 1'b0;
    chk("drain_req", bus.req, 1'b1);
    chk("drain_stall", stall, 1'b1);
    tick();
    chk("drain_req_hold", bus.req, 1'b1);
    bus.ack = 1'b1; bus.rdata = 32'h5555_AAAA;
    #1;
    chk("drain_stall_ack", stall, 1'b1);
    tick();
    bus.ack = 1'b0; valid = 1'b0; ram_op = MEM_NOP;
    chk("drain_req_drop", bus.req, 1'b0);
    chk("drain_no_wb", wb_valid, 1'b0);
    chk("drain_no_exc", exc_valid, 1'b0);

    // flush in IDLE: nothing retires, no transfer starts
    valid = 1'b1; ram_op = MEM_LW; addr = 32'h3010; wr_en = 1'b1; flush = 1'b1;
    tick();
    chk("flush_idle_req", bus.req, 1'b0);
    chk("flush_idle_wb", wb_valid, 1'b0);
    valid = 1'b0; ram_op = MEM_NOP; flush = 1'b0;

    // reset in the middle of a transfer
    valid = 1'b1; ram_op = MEM_SW; addr = 32'h2008; wdata = 32'h1;
    tick();
    chk("rst_mid_req_busy", bus.req, 1'b1);
    rst = 1'b1; valid = 1'b0; ram_op = MEM_NOP;
    tick();
    chk("rst_mid_req", bus.req, 1'b0);
    chk("rst_mid_stall", stall, 1'b0);
    chk("rst_mid_wb", wb_valid, 1'b0);
    rst = 1'b0;
    tick();

    // back to normal operation after reset
    mem_xfer(MEM_LB, 32'h1001, 32'h0, 32'h0000_7F00, 0, 1'b0, 1'b1, 5'd13);
    chk("sb_final", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
